// File: rtl/crypto1_keystream_if.sv
// Request/response and serial-stream signals between a keystream consumer and crypto1_keystream.
// The consumer drives START, KEY and BIT_READY; the generator drives everything else.
interface crypto1_keystream_if;
  logic        START;
  logic [47:0] KEY;
  logic        BUSY;
  logic        DONE;
  logic [47:0] BITSTREAM;
  logic        BIT_VALID;
  logic        BIT_DATA;
  logic        BIT_READY;

  modport master (
    output START, KEY, BIT_READY,
    input  BUSY, DONE, BITSTREAM, BIT_VALID, BIT_DATA
  );

  modport slave (
    input  START, KEY, BIT_READY,
    output BUSY, DONE, BITSTREAM, BIT_VALID, BIT_DATA
  );
endinterface

// File: rtl/crypto1_keystream.sv
// Crypto1 keystream generator: loads a 48-bit key and produces 48 filtered keystream bits, MSB first.
// Define CRYPTO1_KEYSTREAM_STREAM_EN to enable the BIT_VALID/BIT_READY serial stream with backpressure.
module crypto1_keystream #(
  parameter logic [47:0] TAPS = 48'h846B50D4_1170
) (
  input logic                 CLK,
  input logic                 RESETn,
  crypto1_keystream_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [31:0] FC_TABLE = 32'hEC57E80A;

  logic [1:0]  state;
  logic [47:0] lfsr;
  logic [5:0]  cnt;
  logic        busy;
  logic        done;
  logic [47:0] bitstream;
  logic        ks_bit;
  logic        advance;
  logic [5:0]  bit_idx;
  logic [4:0]  fc_idx;

  function automatic logic fa(input logic a, input logic b, input logic c, input logic d);
    return ((a | b) ^ (a & d)) ^ (c & ((a ^ b) | d));
  endfunction

  function automatic logic fb(input logic a, input logic b, input logic c, input logic d);
    return ((a & b) | c) ^ ((a ^ b) & (c | d));
  endfunction

  // LFSR[47-k] holds stream bit x_k, so the odd taps x9..x47 sit on the even LFSR bits 38..0.
  always_comb begin
    fc_idx = {fb(lfsr[6],  lfsr[4],  lfsr[2],  lfsr[0]),
              fa(lfsr[14], lfsr[12], lfsr[10], lfsr[8]),
              fb(lfsr[22], lfsr[20], lfsr[18], lfsr[16]),
              fb(lfsr[30], lfsr[28], lfsr[26], lfsr[24]),
              fa(lfsr[38], lfsr[36], lfsr[34], lfsr[32])};
    ks_bit = FC_TABLE[fc_idx];
  end

  assign bit_idx = 6'd47 - cnt;

`ifdef CRYPTO1_KEYSTREAM_STREAM_EN
  assign advance       = (state == RUN) && bus.BIT_READY;
  assign bus.BIT_VALID = (state == RUN);
  assign bus.BIT_DATA  = (state == RUN) && ks_bit;
`else
  logic unused_bit_ready;
  assign unused_bit_ready = bus.BIT_READY;
  assign advance          = (state == RUN);
  assign bus.BIT_VALID    = 1'b0;
  assign bus.BIT_DATA     = 1'b0;
`endif

  // The final advancing edge records bit 0 and freezes the LFSR and counter in FIN.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      lfsr      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bitstream <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (bus.START) begin
            lfsr      <= bus.KEY;
            cnt       <= '0;
            done      <= 1'b0;
            bitstream <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            bitstream[bit_idx] <= ks_bit;
            if (cnt == 6'd47) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              lfsr <= {lfsr[46:0], ^(TAPS & lfsr)};
              cnt  <= cnt + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.BITSTREAM = bitstream;

endmodule

// File: doc/crypto1_keystream.md
CRYPTO1_KEYSTREAM -- requirements
Module: crypto1_keystream

Interface
REQ-001 SHALL have parameter TAPS, default 48'h846B50D4_1170 (Crypto1 feedback polynomial), meaning feedback tap mask over LFSR bits 47:0.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESETn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port START, input, 1, a request to generate a keystream from KEY.
REQ-005 SHALL have port KEY, input, 48, the initial LFSR state, sampled only when START is accepted.
REQ-006 SHALL have port BUSY, output, 1, high while generation is in progress.
REQ-007 SHALL have port DONE, output, 1, high when BITSTREAM is complete; it holds until the next accepted START.
REQ-008 SHALL have port BITSTREAM, output, 48, the keystream, with the first bit generated in bit 47.
REQ-009 SHALL have port BIT_VALID, output, 1, a serial keystream bit is presented.
REQ-010 SHALL have port BIT_DATA, output, 1, the serial keystream bit, MSB (first generated) first.
REQ-011 SHALL have port BIT_READY, input, 1, the consumer accepts BIT_DATA.

Function
REQ-012 SHALL implement states IDLE, RUN and FIN; the state after reset is IDLE.
REQ-013 In IDLE or FIN with START=1, the next edge SHALL load the LFSR with KEY, clear the 6-bit counter CNT, clear DONE and BITSTREAM, set BUSY=1 and enter RUN.
REQ-014 START SHALL be ignored while in RUN.
REQ-015 On an advancing RUN edge, the block SHALL:
  - write BITSTREAM[47-CNT] <= f(LFSR), where f is the Crypto1 filter function defined in crypto1.vh, applied to LFSR[47:0];
  - update LFSR <= {LFSR[46:0], ^(TAPS & LFSR)};
  - increment CNT.
REQ-016 An advancing edge with CNT=47 SHALL enter FIN, set DONE=1 and BUSY=0, and hold BITSTREAM and the LFSR.
REQ-017 Without stalls, DONE SHALL rise exactly 48 cycles after the edge that accepted START.
REQ-018 FIN SHALL hold all outputs until an accepted START.
REQ-019 LFSR width and CNT arithmetic SHALL NOT wrap; CNT never exceeds 47 in RUN.
REQ-020 A bit generated as BITSTREAM[47-i] SHALL equal the bit the key search core compares at that same BITSTREAM index for the same key.

Reset
REQ-021 RESETn low SHALL asynchronously force the following:
  - state to IDLE;
  - BUSY, DONE, BIT_VALID and BIT_DATA to 0;
  - BITSTREAM, LFSR and CNT to 0.
REQ-022 Reset asserted mid-RUN SHALL abandon generation with no partial DONE; the first START after release restarts from KEY.
REQ-023 Reset deassertion SHALL take effect at the next CLK edge; START is sampled only on edges where RESETn is high.

Configuration
REQ-024 Macro CRYPTO1_KEYSTREAM_STREAM_EN SHALL control the serial stream interface.
REQ-025 With CRYPTO1_KEYSTREAM_STREAM_EN defined:
  - in RUN, BIT_VALID=1 and BIT_DATA=f(LFSR) combinationally;
  - an edge is advancing only when BIT_VALID and BIT_READY are both high;
  - BIT_READY low stalls the LFSR, CNT and BITSTREAM;
  - BIT_VALID=0 outside RUN.
REQ-026 Without CRYPTO1_KEYSTREAM_STREAM_EN:
  - every RUN edge is advancing;
  - BIT_READY is ignored;
  - BIT_VALID and BIT_DATA are tied to 0.

Verification
REQ-027 KEY=48'h0, START pulse -> BUSY for 48 cycles, then DONE=1, BITSTREAM=48'h0.
REQ-028 KEY=48'hA0A1A2A3A4A5, START pulse -> BITSTREAM matches the crapto1 software model over 48 bits; DONE at cycle 48.
REQ-029 Feed the REQ-028 BITSTREAM to Crypto1Core with matching EIDX/OIDX -> VALID=1 and KEY=48'hA0A1A2A3A4A5.
REQ-030 STREAM_EN with BIT_READY toggled 1/0 per cycle -> serial bits match the REQ-028 BITSTREAM MSB-first; DONE at cycle 96.
REQ-031 START re-pulsed at cycle 10 of RUN -> ignored; result identical to REQ-028.
REQ-032 RESETn pulsed low at cycle 20 of RUN -> outputs 0 immediately; a new START with KEY=48'hFFFFFFFFFFFF gives BITSTREAM equal to the model output and DONE after 48 cycles.
